// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg : shared types and helpers for the BCD score countdown. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 4;

  function automatic logic bcd_is_zero(input logic [4*MAX_DIGITS-1:0] v);
    return (v == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_updown_chain.sv
// ---------------------------------------------------------------------------
// bcd_updown_chain : one player's DIGITS-digit BCD score register with load,
// decrement and (under SCORE_PENALTY_EN) saturating increment.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_updown_chain
  import score_pkg::*;
#(
  parameter int                  DIGITS    = 2,
  parameter logic [4*DIGITS-1:0] START_BCD = 8'h32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                dec,
`ifdef SCORE_PENALTY_EN
  input  logic                inc,
`endif
  output logic [4*DIGITS-1:0] value,
  output logic                dec_zero
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]              dec_val;
  logic [4*MAX_DIGITS-1:0]   dec_ext;

  // Borrow ripples upward: a zero digit becomes 9 and keeps the borrow alive.
  always_comb begin
    logic       borrow;
    bcd_digit_t dig;
    dec_val = value;
    borrow  = 1'b1;
    dig     = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = value[4*d +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = BCD_MAX;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      dec_val[4*d +: 4] = dig;
    end
    dec_ext        = '0;
    dec_ext[W-1:0] = dec_val;
  end

  assign dec_zero = dec & bcd_is_zero(dec_ext);

`ifdef SCORE_PENALTY_EN
  logic [W-1:0] inc_val;

  always_comb begin
    logic       carry;
    bcd_digit_t dig;
    inc_val = value;
    carry   = 1'b1;
    dig     = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = value[4*d +: 4];
      if (carry) begin
        if (dig == BCD_MAX) begin
          dig = 4'd0;
        end else begin
          dig   = dig + 4'd1;
          carry = 1'b0;
        end
      end
      inc_val[4*d +: 4] = dig;
    end
  end

  // Packed BCD orders the same as binary, so a plain compare saturates.
  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      value <= START_BCD;
    end else if (dec) begin
      value <= dec_val;
    end else if (inc && (value < START_BCD)) begin
      value <= inc_val;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!resetn || load) begin
      value <= START_BCD;
    end else if (dec) begin
      value <= dec_val;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/bcd_score_countdown.sv
// ---------------------------------------------------------------------------
// bcd_score_countdown : multi-player BCD score countdown with game FSM and
// winner select; SCORE_PENALTY_EN enables miss-key increments.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_score_countdown
  import score_pkg::*;
#(
  parameter int                  DIGITS    = 2,
  parameter int                  PLAYERS   = 2,
  parameter logic [4*DIGITS-1:0] START_BCD = 8'h32,
  localparam int                 WW        = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [PLAYERS-1:0]          hit,
  input  logic [PLAYERS-1:0]          miss,
  output logic [4*DIGITS*PLAYERS-1:0] score_bcd,
  output logic [PLAYERS-1:0]          ended,
  output logic                        game_over,
  output logic [WW-1:0]               winner
);

  state_t             state, state_next;
  logic [PLAYERS-1:0] hit_q, hit_ev, dec, dec_zero;
  logic [WW-1:0]      win_idx;
  logic               active;

  assign hit_ev = hit & ~hit_q;
  // Events arriving alongside start are dropped; the reload wins.
  assign active = (state == RUN) && !start;

`ifdef SCORE_PENALTY_EN
  logic [PLAYERS-1:0] miss_q, miss_ev, inc;

  assign miss_ev = miss & ~miss_q;
  assign dec     = {PLAYERS{active}} & hit_ev & ~miss_ev;
  assign inc     = {PLAYERS{active}} & miss_ev & ~hit_ev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss;
    end
  end
`else
  logic unused_miss;

  assign unused_miss = ^miss;
  assign dec         = {PLAYERS{active}} & hit_ev;
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    bcd_updown_chain #(
      .DIGITS    (DIGITS),
      .START_BCD (START_BCD)
    ) u_chain (
      .clk      (clk),
      .resetn   (resetn),
      .load     (start),
      .dec      (dec[p]),
`ifdef SCORE_PENALTY_EN
      .inc      (inc[p]),
`endif
      .value    (score_bcd[p*4*DIGITS +: 4*DIGITS]),
      .dec_zero (dec_zero[p])
    );
  end

  // Lowest index wins when several players hit zero on the same edge.
  always_comb begin
    win_idx = '0;
    for (int p = PLAYERS - 1; p >= 0; p--) begin
      if (dec_zero[p]) begin
        win_idx = WW'(p);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start) begin
          state_next = RUN;
        end else if (|dec_zero) begin
          state_next = DONE;
        end
      end
      DONE: if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      hit_q     <= '0;
      ended     <= '0;
      game_over <= 1'b0;
      winner    <= '0;
    end else begin
      state     <= state_next;
      hit_q     <= hit;
      game_over <= (state_next == DONE);
      if (start) begin
        ended  <= '0;
        winner <= '0;
      end else if (|dec_zero) begin
        ended  <= dec_zero;
        winner <= win_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_countdown.sv
// ---------------------------------------------------------------------------
// tb_bcd_score_countdown : directed plus random bench with a decimal-score
// reference model for bcd_score_countdown.                          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_score_countdown;

  localparam int              DIGITS    = 2;
  localparam int              PLAYERS   = 2;
  localparam logic [7:0]      START_BCD = 8'h32;
  localparam int              START_VAL = 32;

  logic                        clk = 1'b0;
  logic                        resetn = 1'b0;
  logic                        start = 1'b0;
  logic [PLAYERS-1:0]          hit = '0;
  logic [PLAYERS-1:0]          miss = '0;
  logic [4*DIGITS*PLAYERS-1:0] score_bcd;
  logic [PLAYERS-1:0]          ended;
  logic                        game_over;
  logic [0:0]                  winner;

  always #5 clk = ~clk;

  bcd_score_countdown #(
    .DIGITS    (DIGITS),
    .PLAYERS   (PLAYERS),
    .START_BCD (START_BCD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .score_bcd (score_bcd),
    .ended     (ended),
    .game_over (game_over),
    .winner    (winner)
  );

  // Reference model: scores kept as plain decimal integers.
  int                 m_score [PLAYERS];
  logic [PLAYERS-1:0] m_ended;
  logic               m_over;
  int                 m_win;
  bit                 m_run;
  logic [PLAYERS-1:0] m_hprev, m_mprev;

  int checks = 0;
  int passes = 0;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [PLAYERS-1:0] hev, mev, newly;
    hev   = hit & ~m_hprev;
    mev   = '0;
`ifdef SCORE_PENALTY_EN
    mev   = miss & ~m_mprev;
`endif
    newly = '0;
    if (!resetn) begin
      for (int p = 0; p < PLAYERS; p++) m_score[p] = START_VAL;
      m_ended = '0;
      m_over  = 1'b0;
      m_win   = 0;
      m_run   = 1'b0;
      m_hprev = '0;
      m_mprev = '0;
    end else begin
      if (start) begin
        for (int p = 0; p < PLAYERS; p++) m_score[p] = START_VAL;
        m_ended = '0;
        m_over  = 1'b0;
        m_win   = 0;
        m_run   = 1'b1;
      end else if (m_run) begin
        for (int p = 0; p < PLAYERS; p++) begin
          if (hev[p] && !mev[p]) begin
            m_score[p] = m_score[p] - 1;
            if (m_score[p] == 0) newly[p] = 1'b1;
          end else if (mev[p] && !hev[p] && m_score[p] < START_VAL) begin
            m_score[p] = m_score[p] + 1;
          end
        end
        if (newly != '0) begin
          m_ended = newly;
          m_over  = 1'b1;
          m_run   = 1'b0;
          m_win   = -1;
          for (int p = 0; p < PLAYERS; p++)
            if (newly[p] && m_win < 0) m_win = p;
        end
      end
      m_hprev = hit;
      m_mprev = miss;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < PLAYERS; p++)
      chk($sformatf("score_p%0d", p), 32'(score_bcd[p*4*DIGITS +: 4*DIGITS]), 32'(to_bcd(m_score[p])));
    chk("ended", 32'(ended), 32'(m_ended));
    chk("game_over", 32'(game_over), 32'(m_over));
    if (m_over) chk("winner", 32'(winner), 32'(m_win));
  endtask

  task automatic cycle(input logic rn, input logic st, input logic [PLAYERS-1:0] h,
                       input logic [PLAYERS-1:0] m);
    @(negedge clk);
    resetn = rn;
    start  = st;
    hit    = h;
    miss   = m;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulses(input int n, input logic [PLAYERS-1:0] h);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, h, '0);
      cycle(1'b1, 1'b0, '0, '0);
    end
  endtask

  initial begin
    // Reset, start, three hits on P0
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 2'b11, 2'b11);
    cycle(1'b1, 1'b1, '0, '0);
    pulses(3, 2'b01);
    chk("p0_after_3_hits", 32'(score_bcd[7:0]), 32'h29);
    chk("p1_untouched", 32'(score_bcd[15:8]), 32'h32);

    // Miss pulse from 29, then a miss at the ceiling
    cycle(1'b1, 1'b0, '0, 2'b01);
    cycle(1'b1, 1'b0, '0, '0);
`ifdef SCORE_PENALTY_EN
    chk("p0_after_miss", 32'(score_bcd[7:0]), 32'h30);
`else
    chk("p0_after_miss", 32'(score_bcd[7:0]), 32'h29);
`endif
    cycle(1'b1, 1'b0, 2'b01, 2'b01);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, '0, '0);
    cycle(1'b1, 1'b0, '0, 2'b10);
    cycle(1'b1, 1'b0, '0, '0);
    chk("p1_miss_at_ceiling", 32'(score_bcd[15:8]), 32'h32);

    // Held key counts once
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 2'b01, '0);
    cycle(1'b1, 1'b0, '0, '0);
    chk("p0_held_key", 32'(score_bcd[7:0]), 32'h31);

    // P1 counts all the way down, then the game is frozen
    cycle(1'b1, 1'b1, '0, '0);
    pulses(32, 2'b10);
    chk("p1_zero_ended", 32'(ended), 32'b10);
    chk("p1_zero_winner", 32'(winner), 32'd1);
    pulses(3, 2'b01);
    chk("p0_frozen", 32'(score_bcd[7:0]), 32'h32);

    // Tie: both reach zero together, lowest index wins
    cycle(1'b1, 1'b1, '0, '0);
    pulses(31, 2'b11);
    chk("tie_p0_at_01", 32'(score_bcd[7:0]), 32'h01);
    pulses(1, 2'b11);
    chk("tie_ended", 32'(ended), 32'b11);
    chk("tie_winner", 32'(winner), 32'd0);

    // Reset mid-run while hits pulse, then hits ignored in IDLE
    cycle(1'b1, 1'b1, '0, '0);
    pulses(4, 2'b01);
    cycle(1'b0, 1'b0, 2'b01, '0);
    chk("reset_midrun_p0", 32'(score_bcd[7:0]), 32'h32);
    cycle(1'b1, 1'b0, '0, '0);
    pulses(4, 2'b11);
    chk("idle_ignores_hits", 32'(score_bcd[15:0]), 32'h3232);

    // Random traffic
    cycle(1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 39) == 0),
            PLAYERS'($urandom),
            PLAYERS'($urandom_range(0, 3) == 0 ? $urandom : 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
